// File: rtl/wdt_supervisor.sv
// Watchdog supervisor: kicks an external 4-bit watchdog, holds system reset after timeouts, locks out after MAX_FAULTS.
// Define WDT_SUPERVISOR_HEARTBEAT_EN to gate each kick on a software heartbeat seen since the previous kick point.
module wdt_supervisor #(
    parameter int KICK_PERIOD = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_FAULTS  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       heartbeat,
    input  logic       timeout,
    output logic       restart,
    output logic       wdt_enable,
    output logic       sys_rst_req,
    output logic [1:0] fault_count,
    output logic       locked
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, LOCK} state_t;

    localparam logic [3:0] KickLast  = 4'(KICK_PERIOD - 1);
    localparam logic [3:0] HoldLast  = 4'(HOLD_CYCLES - 1);
    localparam logic [1:0] FaultMax  = 2'(MAX_FAULTS);

    state_t     r_state;
    logic [3:0] r_kickCnt;
    logic [3:0] r_holdCnt;
    logic       r_restart;
    logic       r_wdtEnable;
    logic       r_sysRstReq;
    logic [1:0] r_faultCount;
    logic       r_locked;
    logic       w_kickPoint;
    logic       w_kickOk;

    assign w_kickPoint = (r_kickCnt == KickLast);

`ifdef WDT_SUPERVISOR_HEARTBEAT_EN
    logic r_hbLatch;

    // Remembers a heartbeat between kick points; a same-cycle heartbeat also counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hbLatch <= 1'b0;
        end else if (r_state == RUN) begin
            if (w_kickPoint) begin
                r_hbLatch <= 1'b0;
            end else if (heartbeat) begin
                r_hbLatch <= 1'b1;
            end
        end
    end

    assign w_kickOk = r_hbLatch | heartbeat;
`else
    logic w_unusedHeartbeat;

    assign w_unusedHeartbeat = heartbeat;
    assign w_kickOk          = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_kickCnt    <= 4'd0;
            r_holdCnt    <= 4'd0;
            r_restart    <= 1'b1;
            r_wdtEnable  <= 1'b0;
            r_sysRstReq  <= 1'b0;
            r_faultCount <= 2'd0;
            r_locked     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_kickCnt <= 4'd0;
                    if (enable) begin
                        r_state     <= RUN;
                        r_restart   <= 1'b0;
                        r_wdtEnable <= 1'b1;
                    end
                end
                RUN: begin
                    // Timeout outranks both disable and a coinciding kick point.
                    if (timeout) begin
                        r_state     <= HOLD;
                        r_holdCnt   <= 4'd0;
                        r_restart   <= 1'b1;
                        r_wdtEnable <= 1'b0;
                        r_sysRstReq <= 1'b1;
                        if (r_faultCount < FaultMax) begin
                            r_faultCount <= r_faultCount + 2'd1;
                        end
                    end else if (!enable) begin
                        r_state     <= IDLE;
                        r_restart   <= 1'b1;
                        r_wdtEnable <= 1'b0;
                    end else if (w_kickPoint) begin
                        r_kickCnt <= 4'd0;
                        r_restart <= w_kickOk;
                    end else begin
                        r_kickCnt <= r_kickCnt + 4'd1;
                        r_restart <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_holdCnt == HoldLast) begin
                        if (r_faultCount == FaultMax) begin
                            r_state  <= LOCK;
                            r_locked <= 1'b1;
                        end else if (!enable) begin
                            r_state     <= IDLE;
                            r_sysRstReq <= 1'b0;
                        end else begin
                            r_state     <= RUN;
                            r_kickCnt   <= 4'd0;
                            r_restart   <= 1'b0;
                            r_wdtEnable <= 1'b1;
                            r_sysRstReq <= 1'b0;
                        end
                    end else begin
                        r_holdCnt <= r_holdCnt + 4'd1;
                    end
                end
                LOCK: begin
                    r_state <= LOCK;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign restart     = r_restart;
    assign wdt_enable  = r_wdtEnable;
    assign sys_rst_req = r_sysRstReq;
    assign fault_count = r_faultCount;
    assign locked      = r_locked;

endmodule

// File: tb/tb_wdt_supervisor.sv
// Directed bench for wdt_supervisor at default parameters; expectations follow the build's heartbeat option.
module tb_wdt_supervisor;

`ifdef WDT_SUPERVISOR_HEARTBEAT_EN
    localparam bit HbGated = 1'b1;
`else
    localparam bit HbGated = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       heartbeat;
    logic       timeout;
    logic       restart;
    logic       wdt_enable;
    logic       sys_rst_req;
    logic [1:0] fault_count;
    logic       locked;

    int checks = 0;
    int errors = 0;

    wdt_supervisor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .heartbeat  (heartbeat),
        .timeout    (timeout),
        .restart    (restart),
        .wdt_enable (wdt_enable),
        .sys_rst_req(sys_rst_req),
        .fault_count(fault_count),
        .locked     (locked)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Drives all functional inputs in one step.
    task automatic applyStimulus(input logic en, input logic hb, input logic to);
        enable    = en;
        heartbeat = hb;
        timeout   = to;
    endtask

    // Advances to 1 unit after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares every output against hand-derived values.
    task automatic checkOutput(input string tag, input logic expRestart, input logic expWdt,
                               input logic expSys, input logic [1:0] expFault, input logic expLocked);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {restart, wdt_enable, sys_rst_req, fault_count, locked};
        exp = {expRestart, expWdt, expSys, expFault, expLocked};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed {restart,wdt_en,sys_rst,fault[1:0],locked}=%b expected=%b at %0t",
                     tag, obs, exp, $time);
            $error("[TB] check %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state.
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        // Free-running kicks every 8 cycles with heartbeat every 6 cycles.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 100; i++) begin
            checkOutput("run_kick", logic'(i != 0 && i % 8 == 0), 1'b1, 1'b0, 2'd0, 1'b0);
            heartbeat = (i % 6 == 2);
            if (i < 99) tick();
        end

        // Heartbeat stops: one latched kick at 104, later kicks only without gating; timeout at 119.
        heartbeat = 1'b0;
        for (int i = 100; i < 119; i++) begin
            tick();
            checkOutput("hb_stop", logic'(i == 104 || (!HbGated && i == 112)), 1'b1, 1'b0, 2'd0, 1'b0);
        end
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checkOutput("hold1_first", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold1", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        end
        tick();
        checkOutput("hold1_exit_run", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);

        // Timeout on the kick-point cycle: HOLD, no kick first.
        for (int j = 1; j < 8; j++) begin
            tick();
            checkOutput("pre_kick", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
        end
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checkOutput("kick_vs_timeout", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold2", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
        end
        tick();
        checkOutput("hold2_exit_run", 1'b0, 1'b1, 1'b0, 2'd2, 1'b0);

        // Third timeout leads to lockout.
        tick();
        tick();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checkOutput("hold3_first", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("hold3", 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
        end
        tick();
        checkOutput("lock_entry", 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(logic'(k % 2), logic'(k % 3 == 0), logic'(k % 2 == 0));
            tick();
            checkOutput("lock_hold", 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        end

        // Asynchronous reset out of LOCK.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("lock_async_reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("lock_reset_held", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        // Disable during HOLD does not shorten it.
        tick();
        checkOutput("run_after_reset", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checkOutput("hold4_c1", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        tick();
        checkOutput("hold4_c2", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        enable = 1'b0;
        tick();
        checkOutput("hold4_c3", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        tick();
        checkOutput("hold4_c4", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        tick();
        checkOutput("hold4_exit_idle", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
        tick();
        checkOutput("idle_stays", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);

        // Disable in RUN at a kick point returns to IDLE.
        enable = 1'b1;
        tick();
        checkOutput("run_again", 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
        for (int j = 1; j < 8; j++) tick();
        enable = 1'b0;
        tick();
        checkOutput("run_disable_idle", 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);

        // Asynchronous reset in the middle of HOLD.
        enable = 1'b1;
        tick();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        checkOutput("hold5_c1", 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("hold_async_reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("hold_reset_held", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();
        checkOutput("idle_after_reset", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdt_supervisor.md
WDT_SUPERVISOR -- requirements
Module: wdt_supervisor

Interface
REQ-001 The block SHALL have parameter KICK_PERIOD, default 8: cycles between kicks in RUN, legal range 2..14, inside the 4-bit Watchdog's 15-cycle window.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4: length of the HOLD state in cycles, legal range 1..15.
REQ-003 The block SHALL have parameter MAX_FAULTS, default 3: timeout count that causes lockout, legal range 1..3.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: arms supervision.
REQ-007 The block SHALL have port heartbeat, input, 1 bit: one-cycle software-alive pulse.
REQ-008 The block SHALL have port timeout, input, 1 bit: the Watchdog timeout output.
REQ-009 The block SHALL have port restart, output, 1 bit: kick, driving the Watchdog restart input.
REQ-010 The block SHALL have port wdt_enable, output, 1 bit: driving the Watchdog enable input.
REQ-011 The block SHALL have port sys_rst_req, output, 1 bit: system reset request.
REQ-012 The block SHALL have port fault_count, output, 2 bits: number of timeouts seen.
REQ-013 The block SHALL have port locked, output, 1 bit: lockout indicator.
REQ-014 All outputs SHALL be registered.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN, HOLD and LOCK.
REQ-016 In IDLE, the block SHALL drive wdt_enable=0, restart=1 (holding the Watchdog clear) and sys_rst_req=0.
REQ-017 In IDLE, enable=1 SHALL cause entry to RUN on the next edge with the interval counter set to 0.
REQ-018 In RUN, the block SHALL drive wdt_enable=1.
REQ-019 In RUN, the interval counter SHALL increment every cycle.
REQ-020 When the counter equals KICK_PERIOD-1, it SHALL wrap to 0 and restart SHALL be 1 in the following cycle only.
REQ-021 Outside kicks in RUN, restart SHALL be 0.
REQ-022 timeout=1 sampled in RUN SHALL cause entry to HOLD on the next edge and increment fault_count, saturating at MAX_FAULTS.
REQ-023 If timeout and a kick point coincide, timeout SHALL win and HOLD SHALL be entered.
REQ-024 In HOLD, the block SHALL drive sys_rst_req=1, restart=1 and wdt_enable=0 for exactly HOLD_CYCLES cycles.
REQ-025 At the end of HOLD, the FSM SHALL go to LOCK if fault_count==MAX_FAULTS, else to IDLE if enable=0, else to RUN with the counter at 0.
REQ-026 In LOCK, the block SHALL drive sys_rst_req=1, locked=1, restart=1 and wdt_enable=0.
REQ-027 LOCK SHALL be exited only by rst_n.
REQ-028 In LOCK, enable, heartbeat and timeout SHALL be ignored.
REQ-029 enable=0 in RUN SHALL cause a return to IDLE on the next edge; no kick SHALL be issued in that cycle.
REQ-030 enable=0 in HOLD SHALL NOT shorten HOLD.
REQ-031 timeout SHALL be ignored outside RUN.
REQ-032 fault_count SHALL be cleared only by rst_n.

Reset
REQ-033 While rst_n=0, the block SHALL asynchronously force state=IDLE, counters=0, heartbeat latch=0, restart=1, wdt_enable=0, sys_rst_req=0, locked=0 and fault_count=0.
REQ-034 Reset release SHALL be synchronous to clk.
REQ-035 Reset SHALL take effect mid-HOLD and in LOCK with no residual pulse on any output.

Configuration
REQ-036 The macro WDT_SUPERVISOR_HEARTBEAT_EN SHALL select heartbeat-gated kicking.
REQ-037 With WDT_SUPERVISOR_HEARTBEAT_EN defined, a heartbeat=1 in RUN SHALL set a latch.
REQ-038 With WDT_SUPERVISOR_HEARTBEAT_EN defined, a kick SHALL be issued at the kick point only if the latch is set or heartbeat=1 in that same cycle, and the latch SHALL be cleared at every kick point.
REQ-039 With WDT_SUPERVISOR_HEARTBEAT_EN defined, a missed heartbeat SHALL suppress the kick while the counter still wraps.
REQ-040 Without WDT_SUPERVISOR_HEARTBEAT_EN, kicks SHALL be free-running, heartbeat SHALL be ignored and no latch logic SHALL exist.

Verification
REQ-041 The bench SHALL cover: defaults, no macro, enable=1 held for 100 cycles -> restart pulses every 8 cycles, one cycle wide, and sys_rst_req=0 throughout.
REQ-042 The bench SHALL cover: force timeout=1 for 1 cycle in RUN -> HOLD with sys_rst_req=1 for 4 cycles, fault_count=1, then RUN.
REQ-043 The bench SHALL cover: 3 timeouts -> fault_count=3, then LOCK with locked=1 and sys_rst_req=1 held; rst_n low for 1 cycle -> all outputs at reset values.
REQ-044 The bench SHALL cover: macro defined, heartbeat every 6 cycles -> kicks every 8 cycles; heartbeat stopped -> no further kicks, watchdog timeout after 15 cycles -> HOLD.
REQ-045 The bench SHALL cover: timeout asserted on the kick-point cycle -> HOLD entered, with no separate kick pulse before HOLD.
REQ-046 The bench SHALL cover: enable=0 on the second HOLD cycle -> HOLD still lasts 4 cycles, then IDLE with wdt_enable=0.
